// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction-memory
// write path.
package imem_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH  = 256;
  localparam int WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } load_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; byte k fills
// lane k, and the finished word is latched on the last lane.
module word_assembler
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        complete
);

  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0]           byte_cnt;
  logic [8*WORD_BYTES-1:0] lanes;
  logic [8*WORD_BYTES-1:0] merged;

  always_comb begin
    merged = lanes;
    merged[int'(byte_cnt)*8 +: 8] = byte_data;
  end

  assign complete = accept && (byte_cnt == CW'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      lanes    <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (accept) begin
      lanes    <= merged;
      byte_cnt <= byte_cnt + CW'(1);
      // Published word only changes on completion so it stays stable
      // while the next word is being collected.
      if (complete) begin
        word <= merged;
      end
    end
  end

endmodule

// File: rtl/ins_mem_loader.sv
// Streams bytes into instruction-memory words, holding the core in reset
// until the load finishes or aborts.
module ins_mem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W         = IMEM_ADDR_W,
  parameter int MAX_WORDS      = IMEM_DEPTH / WORD_BYTES,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  load_state_t state;
  load_state_t nxt;

  logic [6:0]    n_words;
  logic [6:0]    word_idx;
  logic [TW-1:0] idle_cnt;
  logic          error_q;

  logic accept;
  logic launch;
  logic bad_count;
  logic timeout;
  logic last_word;
  logic complete;

  assign accept    = (state == COLLECT) && byte_valid;
  assign launch    = (state == IDLE) && start;
  assign bad_count = num_words > 7'(MAX_WORDS);
  assign last_word = (word_idx + 7'd1) == n_words;
  assign timeout   = (state == COLLECT) && !byte_valid &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (launch || timeout),
    .accept    (accept),
    .byte_data (byte_data),
    .word      (wr_data),
    .complete  (complete)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_words == 7'd0 || bad_count) begin
            nxt = DONE;
          end else begin
            nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (complete) begin
          nxt = WRITE;
        end else if (timeout) begin
          nxt = DONE;
        end
      end
      WRITE: begin
        nxt = last_word ? DONE : COLLECT;
      end
      DONE: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      n_words  <= '0;
      word_idx <= '0;
      idle_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (launch) begin
        n_words  <= num_words;
        word_idx <= '0;
        error_q  <= bad_count;
      end
      if (state == WRITE) begin
        word_idx <= word_idx + 7'd1;
      end
      if (timeout) begin
        error_q <= 1'b1;
      end
      // Idle gap is measured only while waiting for bytes.
      if (state != COLLECT || byte_valid) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  assign byte_ready = (state == COLLECT);
  assign wr_en      = (state == WRITE);
  assign wr_addr    = ADDR_W'({word_idx, 2'b00});
  assign busy       = (state == COLLECT) || (state == WRITE);
  assign cpu_hold   = busy;
  assign done       = (state == DONE);
  assign error      = error_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: table of loads plus hand-written
// timeout, restart-ignore and async-reset sequences.
module tb_ins_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int busy_drop = 0;
  logic [39:0] wq[$];

  ins_mem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (done) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  nw;
    int          gap;
    logic        exp_err;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  task automatic chk(input string name, input logic [39:0] act,
                     input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int k);
    case (k)
      0: word_of = v.w0;
      1: word_of = v.w1;
      2: word_of = v.w2;
      default: word_of = v.w0 ^ (32'(k) * 32'h9e3779b9);
    endcase
  endfunction

  task automatic pulse_start(input logic [6:0] n);
    num_words = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      if (!busy) busy_drop++;
      if (byte_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    byte_valid = 1'b0;
    if (!ok) chk("byte_accept", 40'(ok), 40'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(gap, 0)) begin
        @(posedge clk); #1;
      end
      send_byte(w[8*b +: 8]);
    end
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < bound && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 40'(seen), 40'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nwr;
    wq.delete();
    done_cnt = 0;
    busy_drop = 0;
    nwr = (v.exp_err || v.nw == 7'd0) ? 0 : int'(v.nw);
    pulse_start(v.nw);
    chk($sformatf("v%0d_busy_start", idx), 40'(busy), 40'(nwr != 0));
    chk($sformatf("v%0d_hold_start", idx), 40'(cpu_hold), 40'(nwr != 0));
    for (int k = 0; k < nwr; k++) send_word(word_of(v, k), v.gap);
    wait_done(40);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d_done_cnt", idx), 40'(done_cnt), 40'd1);
    chk($sformatf("v%0d_error", idx), 40'(error), 40'(v.exp_err));
    chk($sformatf("v%0d_busy_drop", idx), 40'(busy_drop), 40'd0);
    chk($sformatf("v%0d_nwrites", idx), 40'(wq.size()), 40'(nwr));
    for (int k = 0; k < nwr && k < wq.size(); k++) begin
      chk($sformatf("v%0d_wr%0d", idx, k), wq[k],
          {8'(k * 4), word_of(v, k)});
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{7'd2,  0,  1'b0, 32'h00000013, 32'h00100093, 32'h0};
    vecs[1] = '{7'd3,  10, 1'b0, 32'hdeadbeef, 32'h01234567, 32'ha5a55a5a};
    vecs[2] = '{7'd0,  0,  1'b0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{7'd65, 0,  1'b1, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{7'd1,  3,  1'b0, 32'h8badf00d, 32'h0, 32'h0};
    vecs[5] = '{7'd64, 0,  1'b0, 32'h12345678, 32'h9abcdef0, 32'h0f1e2d3c};

    reset = 1'b1;
    start = 1'b0;
    num_words = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {byte_ready, wr_en, busy, cpu_hold, done, error, wr_addr,
         wr_data[25:0]}, 40'd0);
    chk("reset_wr_data", 40'(wr_data), 40'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Timeout after a partial word, then a fresh start clears error
    wq.delete();
    done_cnt = 0;
    pulse_start(7'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (1000) begin
      @(posedge clk); #1;
    end
    chk("to_no_early_done", 40'(done_cnt), 40'd0);
    chk("to_still_busy", 40'(busy), 40'd1);
    wait_done(100);
    chk("to_error", 40'(error), 40'd1);
    chk("to_no_write", 40'(wq.size()), 40'd0);
    pulse_start(7'd1);
    chk("to_error_cleared", 40'(error), 40'd0);
    send_word(32'hcafef00d, 0);
    wait_done(20);
    chk("to_reload_n", 40'(wq.size()), 40'd1);
    if (wq.size() > 0) chk("to_reload_wr", wq[0], {8'd0, 32'hcafef00d});

    // start during COLLECT must not recapture num_words
    wq.delete();
    pulse_start(7'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_start(7'd1);
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(32'h55667788, 0);
    wait_done(20);
    chk("rs_nwrites", 40'(wq.size()), 40'd2);
    if (wq.size() == 2) begin
      chk("rs_wr0", wq[0], {8'd0, 32'h04030201});
      chk("rs_wr1", wq[1], {8'd4, 32'h55667788});
    end

    // Async reset mid-word: outputs clear at once, no further write
    wq.delete();
    pulse_start(7'd3);
    send_word(32'h76543210, 0);
    send_byte(8'haa);
    send_byte(8'hbb);
    send_byte(8'hcc);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_outputs",
        {byte_ready, wr_en, busy, cpu_hold, done, error, wr_addr,
         wr_data[25:0]}, 40'd0);
    chk("ar_wr_data", 40'(wr_data), 40'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ar_nwrites", 40'(wq.size()), 40'd1);
    wq.delete();
    pulse_start(7'd1);
    send_word(32'h0badcafe, 2);
    wait_done(20);
    chk("ar_reload_n", 40'(wq.size()), 40'd1);
    if (wq.size() > 0) chk("ar_reload_wr", wq[0], {8'd0, 32'h0badcafe});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
